byte_lane_packer: RTL and testbench

//   Upstream producer for packed-array consumers. Accepts a byte stream
//   (valid/ready) and packs consecutive bytes into one 2-D packed word,

---
 rtl/byte_lane_packer_if.sv | 27 ++
 rtl/byte_lane_packer.sv | 125 ++++++++++++
 tb/tb_byte_lane_packer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_lane_packer_if.sv
// rtl/byte_lane_packer_if.sv - byte-in / packed-word-out stream bundle for the lane packer
interface byte_lane_packer_if #(
    parameter int LANES = 4,
    parameter int W     = 8
);
    logic                        in_valid;
    logic                        in_ready;
    logic [W-1:0]                in_data;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANES-1:0][W-1:0]     out_data;
    logic [LANES-1:0]            out_keep;
    logic                        out_last;

    // master: the environment (byte producer and word consumer)
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_keep, out_last
    );

    // slave: the packer itself
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_keep, out_last
    );
endinterface

// File: rtl/byte_lane_packer.sv
// rtl/byte_lane_packer.sv - packs a byte stream into LANES-wide words, lane 0 first, keep mask on flush
module byte_lane_packer #(
    parameter int LANES = 4,
    parameter int W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    byte_lane_packer_if.slave    bus
);
    localparam int IW = $clog2(LANES);

    typedef enum logic {FILL, PEND} state_t;

    state_t                    state, state_next;
    logic [IW-1:0]             idx;
    logic [LANES-1:0][W-1:0]   asm_data;
    logic [LANES-1:0]          asm_keep;
    logic                      asm_last;

    logic [LANES-1:0][W-1:0]   merged_data;
    logic [LANES-1:0]          merged_keep;
    logic                      slot_free;
    logic                      completing;
    logic                      accept;
    logic                      load_byte;
    logic                      load_asm;
    logic                      latch_pend;

    assign slot_free  = !bus.out_valid || bus.out_ready;
    assign completing = (idx == IW'(LANES - 1)) || bus.in_last;

    // Finished word as it would look with the incoming byte in lane idx; lanes never written stay zero.
    always_comb begin
        merged_keep      = asm_keep;
        merged_keep[idx] = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            merged_data[k] = merged_keep[k] ? asm_data[k] : '0;
        end
        merged_data[idx] = bus.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        bus.in_ready = 1'b0;
        accept       = 1'b0;
        load_byte    = 1'b0;
        load_asm     = 1'b0;
        latch_pend   = 1'b0;
        case (state)
            FILL: begin
                bus.in_ready = 1'b1;
                accept       = bus.in_valid;
                if (accept && completing) begin
                    if (slot_free) begin
                        load_byte = 1'b1;
                    end else begin
                        latch_pend = 1'b1;
                        state_next = PEND;
                    end
                end
            end
            PEND: begin
                if (slot_free) begin
                    load_asm   = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx           <= '0;
            asm_data      <= '0;
            asm_keep      <= '0;
            asm_last      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_keep  <= '0;
            bus.out_last  <= 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (load_byte) begin
                bus.out_data  <= merged_data;
                bus.out_keep  <= merged_keep;
                bus.out_last  <= bus.in_last;
                bus.out_valid <= 1'b1;
                idx           <= '0;
                asm_data      <= '0;
                asm_keep      <= '0;
                asm_last      <= 1'b0;
            end else if (latch_pend) begin
                // Assembly buffer doubles as the holding slot while the output is stalled.
                asm_data <= merged_data;
                asm_keep <= merged_keep;
                asm_last <= bus.in_last;
            end else if (accept) begin
                asm_data[idx] <= bus.in_data;
                asm_keep[idx] <= 1'b1;
                idx           <= idx + IW'(1);
            end
            if (load_asm) begin
                bus.out_data  <= asm_data;
                bus.out_keep  <= asm_keep;
                bus.out_last  <= asm_last;
                bus.out_valid <= 1'b1;
                idx           <= '0;
                asm_data      <= '0;
                asm_keep      <= '0;
                asm_last      <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_byte_lane_packer.sv
// tb/tb_byte_lane_packer.sv - scoreboard bench for byte_lane_packer with per-scenario tasks
module tb_byte_lane_packer;
    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } word_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   words_seen;

    word_t          exp_q[$];
    logic [3:0][7:0] m_buf;
    logic [3:0]     m_keep;
    int             m_idx;

    byte_lane_packer_if #(.LANES(4), .W(8)) bus ();

    byte_lane_packer #(.LANES(4), .W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_push(input logic [7:0] d, input logic l);
        m_buf[m_idx]  = d;
        m_keep[m_idx] = 1'b1;
        if (m_idx == 3 || l) begin
            exp_q.push_back({l, m_keep, m_buf});
            m_buf  = '0;
            m_keep = '0;
            m_idx  = 0;
        end else begin
            m_idx++;
        end
    endfunction

    function automatic void model_clear();
        m_buf  = '0;
        m_keep = '0;
        m_idx  = 0;
        exp_q.delete();
    endfunction

    // Scoreboard: every output handshake is popped and compared against the model.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            word_t got;
            word_t exp;
            got = {bus.out_last, bus.out_keep, bus.out_data};
            vectors++;
            words_seen++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_extra: got %h, expected no word", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    miscompares++;
                    $display("FAIL scoreboard_word: got last=%b keep=%h data=%h, expected last=%b keep=%h data=%h",
                             got.last, got.keep, got.data, exp.last, exp.keep, exp.data);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l, output int waits);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        waits = n;
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: byte %h not accepted after %0d cycles", d, n);
        end else begin
            model_push(d, l);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.out_valid, bus.out_keep, bus.out_last, bus.out_data} !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b keep=%h last=%b data=%h, expected all 0",
                     bus.out_valid, bus.out_keep, bus.out_last, bus.out_data);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
        end
    endtask

    task automatic test_full_words();
        int w;
        int start = words_seen;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h11 * (i + 1), 1'b0, w);
            if (i == 2) begin
                vectors++;
                if (bus.out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_early_valid: got %b, expected 0", bus.out_valid);
                end
            end
            if (i == 3) begin
                vectors++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h44332211 || bus.out_keep !== 4'hF || bus.out_last !== 1'b0) begin
                    miscompares++;
                    $display("FAIL full_word1: got valid=%b data=%h keep=%h last=%b, expected 1 44332211 f 0",
                             bus.out_valid, bus.out_data, bus.out_keep, bus.out_last);
                end
            end
        end
        drain();
        vectors++;
        if (words_seen - start !== 2 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL full_count: got %0d words (%0d pending), expected 2", words_seen - start, exp_q.size());
        end
    endtask

    task automatic test_partial();
        int w;
        send_byte(8'hAA, 1'b0, w);
        send_byte(8'hBB, 1'b0, w);
        send_byte(8'hCC, 1'b1, w);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00CCBBAA || bus.out_keep !== 4'h7 || bus.out_last !== 1'b1) begin
            miscompares++;
            $display("FAIL partial_word: got valid=%b data=%h keep=%h last=%b, expected 1 00ccbbaa 7 1",
                     bus.out_valid, bus.out_data, bus.out_keep, bus.out_last);
        end
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0, w);
        vectors++;
        if (bus.out_data !== 32'h04030201 || bus.out_keep !== 4'hF || bus.out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL partial_next_lane0: got data=%h keep=%h last=%b, expected 04030201 f 0",
                     bus.out_data, bus.out_keep, bus.out_last);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int start = words_seen;
        bus.out_ready = 1'b0;
        fork
            begin
                int w;
                for (int i = 0; i < 12; i++) begin
                    send_byte(8'h30 + 8'(i), 1'b0, w);
                    if (i == 7) begin
                        vectors++;
                        if (bus.in_ready !== 1'b0) begin
                            miscompares++;
                            $display("FAIL bp_pend_ready: got in_ready=%b, expected 0", bus.in_ready);
                        end
                    end
                end
            end
            begin
                repeat (20) begin
                    @(posedge clk);
                    #2;
                    if (bus.out_valid) begin
                        vectors++;
                        if (bus.out_data !== 32'h33323130 || bus.out_keep !== 4'hF) begin
                            miscompares++;
                            $display("FAIL bp_hold: got data=%h keep=%h, expected 33323130 f", bus.out_data, bus.out_keep);
                        end
                    end
                end
                vectors++;
                if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL bp_stall_state: got in_ready=%b out_valid=%b, expected 0 1", bus.in_ready, bus.out_valid);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        vectors++;
        if (words_seen - start !== 3 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL bp_count: got %0d words (%0d pending), expected 3", words_seen - start, exp_q.size());
        end
    endtask

    task automatic test_single();
        int w;
        send_byte(8'h5A, 1'b1, w);
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000005A || bus.out_keep !== 4'h1 || bus.out_last !== 1'b1) begin
            miscompares++;
            $display("FAIL single_word: got valid=%b data=%h keep=%h last=%b, expected 1 0000005a 1 1",
                     bus.out_valid, bus.out_data, bus.out_keep, bus.out_last);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        int w;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'hE0 + 8'(i), 1'b0, w);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.out_valid, bus.out_keep, bus.out_last, bus.out_data} !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_async: got valid=%b keep=%h last=%b data=%h, expected all 0",
                     bus.out_valid, bus.out_keep, bus.out_last, bus.out_data);
        end
        model_clear();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0, w);
        vectors++;
        if (bus.out_data !== 32'h04030201 || bus.out_keep !== 4'hF || bus.out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_next_word: got data=%h keep=%h last=%b, expected 04030201 f 0",
                     bus.out_data, bus.out_keep, bus.out_last);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int w;
        int start = words_seen;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'($urandom_range(0, 255)), 1'b0, w);
            vectors++;
            if (w != 0 || bus.in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_stall: byte %0d waited %0d, in_ready=%b, expected 0 and 1", i, w, bus.in_ready);
            end
        end
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hC0 + 8'(i), 1'b1, w);
            vectors++;
            if (w != 0 || bus.out_valid !== 1'b1 || bus.out_data !== {24'h0, 8'hC0 + 8'(i)}) begin
                miscompares++;
                $display("FAIL b2b_reload: pkt %0d waited %0d valid=%b data=%h, expected 0 1 %h",
                         i, w, bus.out_valid, bus.out_data, {24'h0, 8'hC0 + 8'(i)});
            end
        end
        drain();
        vectors++;
        if (words_seen - start !== 8 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d words (%0d pending), expected 8", words_seen - start, exp_q.size());
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        words_seen    = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        model_clear();
        test_reset();
        test_full_words();
        test_partial();
        test_backpressure();
        test_single();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
